// File: rtl/kbd_scan_fifo.sv
// Purpose: buffers PS/2 key-release scancodes for the VGA controller; optional repeat filter via KBD_SCAN_DEDUP_EN.
// Latency: a push at edge N is visible on out_valid/out_code after edge N (show-ahead head).
// Backpressure: out_ready pops the head; when full with no pop, the strobe is dropped and sticky overflow is set.
module kbd_scan_fifo #(
    parameter int          DEPTH   = 8,
    parameter int          AW      = 3,
    parameter logic [15:0] HOLDOFF = 16'd50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_code,
    input  logic          in_flag,
    output logic [7:0]    out_code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam logic [AW:0]   LP_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);
    localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_dup;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_FULL);
    assign w_pop   = !w_empty && out_ready;

`ifdef KBD_SCAN_DEDUP_EN
    logic [15:0] r_timer;
    logic [7:0]  r_last_code;

    // A repeat of the last accepted code is ignored while the holdoff timer runs.
    assign w_dup = (r_timer != 16'd0) && (in_code == r_last_code);

    // Holdoff timer restarts on every accepted push and otherwise counts down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer     <= 16'd0;
            r_last_code <= 8'h00;
        end else if (w_push) begin
            r_timer     <= HOLDOFF;
            r_last_code <= in_code;
        end else if (r_timer != 16'd0) begin
            r_timer <= r_timer - 16'd1;
        end
    end
`else
    logic w_unused_holdoff;
    assign w_unused_holdoff = ^HOLDOFF;
    assign w_dup            = 1'b0;
`endif

    // A full FIFO still accepts a strobe when the head leaves in the same cycle.
    assign w_push = in_flag && !w_dup && (!w_full || w_pop);
    assign w_drop = in_flag && !w_dup && !w_push;

    // Storage is deliberately not reset; out_code is masked while empty instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_code;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push/pop imbalance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LP_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - LP_CNT_ONE;
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear leaves it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign out_valid = !w_empty;
    assign out_code  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule
